// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: valid/ready request, response wait with timeout,
// and a pipeline stall held until the access completes.
module mem_access_unit #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [DATA_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} state_e;

    // Counter value seen during the final permitted WAIT_RSP cycle.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    state_e            state_q;
    logic              req_valid_q;
    logic              req_we_q;
    logic              err_q;
    logic [DATA_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [7:0]        cnt_q;

    logic pending;
    logic misaligned;
    logic timeout_hit;

    assign pending     = memread_i | memwrite_i;
    assign misaligned  = |addr_i[2:0];
    assign timeout_hit = (cnt_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= StIdle;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pending) begin
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            req_addr_q  <= addr_i;
                            req_wdata_q <= wdata_i;
                            req_we_q    <= memwrite_i;
                            req_valid_q <= 1'b1;
                            state_q     <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (req_ready_i) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A response in the last permitted cycle still wins over the timeout.
                    if (rsp_valid_i) begin
                        if (!req_we_q) begin
                            rdata_q <= rsp_rdata_i;
                        end
                        state_q <= StDone;
                    end else if (timeout_hit) begin
                        if (!req_we_q) begin
                            rdata_q <= '0;
                        end
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall_o = arst_n & (((state_q == StIdle) & pending) |
                               (state_q == StReq) | (state_q == StWaitRsp));

    assign req_valid_o = req_valid_q;
    assign req_we_o    = req_we_q;
    assign req_addr_o  = req_addr_q;
    assign req_wdata_o = req_wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access controller for the MEM stage of the 5-stage pipeline. It sits between the EX_MEM and MEM_WB pipeline registers. It takes the memory control and address/data fields from EX_MEM, runs a valid/ready request plus response transaction to data memory, and drives a stall that deasserts the `en` of every pipeline register until the access completes. Load data goes to the `memreg` input of MEM_WB.

## Interface
- `DATA_W`, 64, width of address, write data and read data.
- `TIMEOUT_CYC`, 255, maximum cycles in WAIT_RSP before the access is aborted (range 1..255).
- `clk` in 1: single clock; all state updates on its rising edge.
- `arst_n` in 1: reset, synchronous and active-low (sampled on rising `clk`).
- `memread_i` in 1: load pending (EX_MEM memread output).
- `memwrite_i` in 1: store pending (EX_MEM memwrite output).
- `addr_i` in DATA_W: byte address (EX_MEM aluout output).
- `wdata_i` in DATA_W: store data (EX_MEM dreg2 output).
- `req_valid_o` out 1: memory request valid.
- `req_ready_i` in 1: memory accepts the request.
- `req_we_o` out 1: 1 means write, 0 means read.
- `req_addr_o` out DATA_W: latched request address.
- `req_wdata_o` out DATA_W: latched write data.
- `rsp_valid_i` in 1: response or write acknowledge from memory.
- `rsp_rdata_i` in DATA_W: read data, qualified by `rsp_valid_i`.
- `stall_o` out 1: freeze pipeline. The top level drives every pipeline register `en` with `~stall_o`.
- `rdata_o` out DATA_W: registered load result, connected to MEM_WB memreg input.
- `err_o` out 1: one-cycle pulse in DONE on timeout or misalignment.

## Operation
- FSM states:
  - IDLE
  - REQ
  - WAIT_RSP
  - DONE
- A pending access means `memread_i | memwrite_i`.
- If both `memread_i` and `memwrite_i` are set, the access is a write.
- IDLE:
  - With a pending access and `addr_i[2:0]==0`: latch `addr_i`, `wdata_i` and `we`, then go to REQ.
  - With a pending access and `addr_i[2:0]!=0`: go to DONE with the error flag set and no memory request issued.
- REQ:
  - `req_valid_o=1`; `req_addr_o`, `req_wdata_o` and `req_we_o` are stable from the latches.
  - When `req_valid_o & req_ready_i` at the edge: go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP:
  - `req_valid_o=0`; the counter increments each cycle.
  - `rsp_valid_i` moves the FSM to DONE. On a read, `rdata_o` captures `rsp_rdata_i`; on a write, `rdata_o` is unchanged.
  - If the counter reaches TIMEOUT_CYC without `rsp_valid_i`: go to DONE with the error flag set. `rdata_o` becomes 0 on a read and is unchanged on a write.
- DONE:
  - `stall_o=0`, so all pipeline registers advance on this edge.
  - `err_o` equals the error flag.
  - Next state is IDLE unconditionally. The error flag clears on DONE→IDLE.
- `stall_o` (combinational):
  - 1 in IDLE when an access is pending.
  - 1 in REQ and WAIT_RSP.
  - 0 in DONE and in IDLE with no access pending.
  - 0 while `arst_n==0`.
- `rsp_valid_i` is ignored outside WAIT_RSP, including a response in the same cycle as request acceptance. `req_ready_i` is ignored outside REQ.

## Timing
- Reset values, applied at the first rising edge with `arst_n==0`:
  - state IDLE
  - `req_valid_o=0`, `req_we_o=0`
  - `req_addr_o=0`, `req_wdata_o=0`
  - `rdata_o=0`, `err_o=0`
  - counter 0
- Reset mid-access: the FSM returns to IDLE at that edge and the in-flight request is abandoned. A late `rsp_valid_i` after reset is ignored.
- Minimum latency, with the access visible at cycle 0:
  - Cycle 0, IDLE: stall.
  - Cycle 1, REQ with `req_ready_i=1`.
  - Cycle 2, WAIT_RSP with `rsp_valid_i=1`.
  - Cycle 3, DONE: `stall_o=0`, MEM_WB captures `rdata_o` at the end of the cycle.
  - Result: 3 stall cycles.
- Each cycle of `req_ready_i=0` in REQ, or of `rsp_valid_i=0` in WAIT_RSP, adds exactly one stall cycle.
- Misaligned access: IDLE→DONE, giving 1 stall cycle and `err_o` high for 1 cycle.
- Back-to-back accesses: after DONE the unit is in IDLE one cycle later. If a new access is pending there, `stall_o=1` immediately. There are no bubble cycles beyond the IDLE cycle.
- Timeout: WAIT_RSP lasts exactly TIMEOUT_CYC cycles, then DONE.

## Test plan
- Reset, no memory access for 5 cycles → `stall_o=0`, `req_valid_o=0`, `rdata_o=0`, `err_o=0` every cycle.
- Load at addr 0x40, `req_ready_i=1` immediately, response the next cycle with data 0xDEADBEEF_01234567 → stall for exactly 3 cycles, `req_we_o=0`, `rdata_o` equals that data in DONE, `err_o=0`.
- Store at addr 0x18 with wdata 0x55, `req_ready_i` low for 2 cycles, acknowledge 3 cycles after acceptance → `req_addr_o`/`req_wdata_o` stable throughout REQ, `req_we_o=1`, stall lasts 1+3+3=7 cycles, `rdata_o` unchanged.
- Load at addr 0x43 → no `req_valid_o`, 1 stall cycle, `err_o` pulses for 1 cycle in DONE.
- TIMEOUT_CYC=4, load accepted, no response ever → DONE after 4 WAIT_RSP cycles, `rdata_o=0`, `err_o=1` for one cycle. A late `rsp_valid_i` arriving in IDLE is ignored.
- `arst_n` low for one edge while in WAIT_RSP → next cycle in IDLE, `stall_o=0` with no access pending, `req_valid_o=0`. A subsequent access completes normally.
